// File: rtl/pc_seq_pkg.sv
// Shared PC-source encodings for the PC sequencer and the core control decoder.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        PC_SEL_JUMP  = 2'b00,
        PC_SEL_SEQBR = 2'b01,
        PC_SEL_REG   = 2'b10,
        PC_SEL_RET   = 2'b11
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/target inputs and PC/RAS status outputs of the PC sequencer.
interface pc_sequencer_if #(
    parameter int unsigned N = 16
);
    logic         stall;
    logic [1:0]   pc_sel;
    logic         call;
    logic [N-1:0] jump_addr;
    logic [N-1:0] seq_branch_addr;
    logic [N-1:0] reg_addr;
    logic [N-1:0] pc;
    logic         ras_empty;
    logic         ras_full;
    logic         ras_overflow;
    logic         ras_underflow;

    modport master (
        output stall, pc_sel, call, jump_addr, seq_branch_addr, reg_addr,
        input  pc, ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, pc_sel, call, jump_addr, seq_branch_addr, reg_addr,
        output pc, ras_empty, ras_full, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// simultaneous push+pop on a non-empty stack replaces the top in place.
module ras_stack #(
    parameter int unsigned N         = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] push_data,
    output logic [N-1:0] top_data,
    output logic         empty,
    output logic         full,
    output logic         overflow,
    output logic         underflow
);
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [N-1:0]  mem [RAS_DEPTH];
    logic [PW-1:0] tp_q, tp_d, tp_inc, tp_dec, wr_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty_q, full_q, ovf_q, unf_q;
    logic          wr_en, ovf_set, unf_set;

    assign tp_inc = (tp_q == PW'(RAS_DEPTH - 1)) ? '0 : tp_q + PW'(1);
    assign tp_dec = (tp_q == '0) ? PW'(RAS_DEPTH - 1) : tp_q - PW'(1);

    // Next pointer/count and write decision
    always_comb begin
        tp_d    = tp_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = tp_inc;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (en) begin
            if (pop && !empty_q) begin
                if (push) begin
                    wr_en  = 1'b1;
                    wr_idx = tp_q;
                end else begin
                    tp_d  = tp_dec;
                    cnt_d = cnt_q - CW'(1);
                end
            end else begin
                unf_set = pop;
                if (push) begin
                    wr_en  = 1'b1;
                    wr_idx = tp_inc;
                    tp_d   = tp_inc;
                    if (full_q) ovf_set = 1'b1;
                    else        cnt_d   = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tp_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tp_q    <= tp_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CW'(RAS_DEPTH));
            ovf_q   <= ovf_q | ovf_set;
            unf_q   <= unf_q | unf_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

    assign top_data  = mem[tp_q];
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with four next-PC sources, stall, and a
// return-address stack for call/return.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned  N         = 16,
    parameter int unsigned  RAS_DEPTH = 4,
    parameter logic [N-1:0] RESET_PC  = '0,
    parameter int unsigned  PC_INC    = 1
) (
    input logic          clk,
    input logic          rst,
    pc_sequencer_if.slave bus
);
    localparam logic [N-1:0] INC = N'(PC_INC);

    logic [N-1:0] pc_q, pc_next, pc_inc, top_data;
    logic         ras_en, ras_pop, ras_empty;

    assign pc_inc  = pc_q + INC;
    assign ras_en  = !bus.stall;
    assign ras_pop = (bus.pc_sel == PC_SEL_RET);

    // Return on an empty stack falls through to the sequential address
    always_comb begin
        pc_next = pc_inc;
        case (bus.pc_sel)
            PC_SEL_JUMP:  pc_next = bus.jump_addr;
            PC_SEL_SEQBR: pc_next = bus.seq_branch_addr;
            PC_SEL_REG:   pc_next = bus.reg_addr;
            PC_SEL_RET:   pc_next = ras_empty ? pc_inc : top_data;
            default:      pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)             pc_q <= RESET_PC;
        else if (!bus.stall) pc_q <= pc_next;
    end

    ras_stack #(
        .N         (N),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .en        (ras_en),
        .push      (bus.call),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .empty     (ras_empty),
        .full      (bus.ras_full),
        .overflow  (bus.ras_overflow),
        .underflow (bus.ras_underflow)
    );

    assign bus.pc        = pc_q;
    assign bus.ras_empty = ras_empty;
endmodule

// File: tb/tb_pc_sequencer.sv
// Vector table plus scoreboard queue bench for pc_sequencer.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if #(.N(16)) bus ();

    pc_sequencer #(
        .N         (16),
        .RAS_DEPTH (4),
        .RESET_PC  (16'h0000),
        .PC_INC    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic        e;
        logic        f;
        logic        o;
        logic        u;
    } out_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic [1:0]  sel;
        logic        call;
        logic [15:0] j;
        logic [15:0] s;
        logic [15:0] r;
        out_t        exp;
    } vec_t;

    vec_t tv[$];
    out_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input string nm, input logic r_, input logic st,
                                input logic [1:0] sel, input logic c,
                                input logic [15:0] j, input logic [15:0] s,
                                input logic [15:0] r,
                                input logic [15:0] pc, input logic e,
                                input logic f, input logic o, input logic u);
        vec_t v;
        v.name = nm; v.rst = r_; v.stall = st; v.sel = sel; v.call = c;
        v.j = j; v.s = s; v.r = r;
        v.exp = '{pc: pc, e: e, f: f, o: o, u: u};
        return v;
    endfunction

    task automatic check(input string nm);
        out_t got, want;
        checks++;
        got = '{pc: bus.pc, e: bus.ras_empty, f: bus.ras_full,
                o: bus.ras_overflow, u: bus.ras_underflow};
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got pc=%h", nm, got.pc);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                failures++;
                $display("FAIL %s: got pc=%h e=%b f=%b o=%b u=%b, want pc=%h e=%b f=%b o=%b u=%b",
                         nm, got.pc, got.e, got.f, got.o, got.u,
                         want.pc, want.e, want.f, want.o, want.u);
            end
        end
    endtask

    // Drive at negedge, expectation queued, DUT sampled at the following negedge
    task automatic apply(input vec_t v);
        rst                 = v.rst;
        bus.stall           = v.stall;
        bus.pc_sel          = v.sel;
        bus.call            = v.call;
        bus.jump_addr       = v.j;
        bus.seq_branch_addr = v.s;
        bus.reg_addr        = v.r;
        exp_q.push_back(v.exp);
        @(posedge clk);
        @(negedge clk);
        check(v.name);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ret_pc [4];
        ret_pc[0] = 16'h4001; ret_pc[1] = 16'h3001;
        ret_pc[2] = 16'h2001; ret_pc[3] = 16'h1001;

        rst = 1'b1; bus.stall = 1'b0; bus.pc_sel = 2'b00; bus.call = 1'b0;
        bus.jump_addr = '0; bus.seq_branch_addr = '0; bus.reg_addr = '0;
        @(negedge clk);

        tv.push_back(mk("reset0",      1,0,PC_SEL_JUMP, 0,16'h0055,16'h0066,16'h0077, 16'h0000,1,0,0,0));
        tv.push_back(mk("reset_stall", 1,1,PC_SEL_JUMP, 1,16'h0055,16'h0066,16'h0077, 16'h0000,1,0,0,0));
        tv.push_back(mk("sel_jump",    0,0,PC_SEL_JUMP, 0,16'h0040,16'h1111,16'h2222, 16'h0040,1,0,0,0));
        tv.push_back(mk("sel_reg",     0,0,PC_SEL_REG,  0,16'h3333,16'h4444,16'h1234, 16'h1234,1,0,0,0));
        tv.push_back(mk("sel_seqbr",   0,0,PC_SEL_SEQBR,0,16'h5555,16'hFFFF,16'h6666, 16'hFFFF,1,0,0,0));
        tv.push_back(mk("to_0010",     0,0,PC_SEL_JUMP, 0,16'h0010,16'h7777,16'h8888, 16'h0010,1,0,0,0));
        tv.push_back(mk("call_0100",   0,0,PC_SEL_JUMP, 1,16'h0100,16'h7777,16'h8888, 16'h0100,0,0,0,0));
        tv.push_back(mk("ret_0011",    0,0,PC_SEL_RET,  0,16'h9999,16'h7777,16'h8888, 16'h0011,1,0,0,0));
        tv.push_back(mk("to_ffff",     0,0,PC_SEL_SEQBR,0,16'h9999,16'hFFFF,16'h8888, 16'hFFFF,1,0,0,0));
        tv.push_back(mk("call_wrap",   0,0,PC_SEL_JUMP, 1,16'h0200,16'h7777,16'h8888, 16'h0200,0,0,0,0));
        tv.push_back(mk("ret_wrap0",   0,0,PC_SEL_RET,  0,16'h9999,16'h7777,16'h8888, 16'h0000,1,0,0,0));
        tv.push_back(mk("call_a00",    0,0,PC_SEL_JUMP, 1,16'h0A00,16'h7777,16'h8888, 16'h0A00,0,0,0,0));
        tv.push_back(mk("call_b00",    0,0,PC_SEL_JUMP, 1,16'h0B00,16'h7777,16'h8888, 16'h0B00,0,0,0,0));
        tv.push_back(mk("call_ret",    0,0,PC_SEL_RET,  1,16'h9999,16'h7777,16'h8888, 16'h0A01,0,0,0,0));
        tv.push_back(mk("ret_new_top", 0,0,PC_SEL_RET,  0,16'h9999,16'h7777,16'h8888, 16'h0B01,0,0,0,0));
        tv.push_back(mk("ret_bottom",  0,0,PC_SEL_RET,  0,16'h9999,16'h7777,16'h8888, 16'h0001,1,0,0,0));
        tv.push_back(mk("to_0300",     0,0,PC_SEL_JUMP, 0,16'h0300,16'h7777,16'h8888, 16'h0300,1,0,0,0));
        for (int k = 0; k < 3; k++)
            tv.push_back(mk("stall_hold", 0,1,PC_SEL_JUMP,1,16'h0400,16'h7777,16'h8888, 16'h0300,1,0,0,0));
        tv.push_back(mk("stall_rel",   0,0,PC_SEL_JUMP, 1,16'h0400,16'h7777,16'h8888, 16'h0400,0,0,0,0));
        tv.push_back(mk("ret_0301",    0,0,PC_SEL_RET,  0,16'h9999,16'h7777,16'h8888, 16'h0301,1,0,0,0));

        foreach (tv[i]) apply(tv[i]);

        // Five nested calls into a four-deep stack
        for (int i = 1; i <= 5; i++)
            apply(mk("ovf_call", 0,0,PC_SEL_JUMP,1,16'(i) << 12,16'h7777,16'h8888,
                     16'(i) << 12, 1'b0, (i >= 4), (i == 5), 1'b0));
        for (int k = 0; k < 4; k++)
            apply(mk("ovf_ret", 0,0,PC_SEL_RET,0,16'h9999,16'h7777,16'h8888,
                     ret_pc[k], (k == 3), 1'b0, 1'b1, 1'b0));
        apply(mk("underflow",    0,0,PC_SEL_RET, 0,16'h9999,16'h7777,16'h8888, 16'h1002,1,0,1,1));
        apply(mk("sticky",       0,0,PC_SEL_JUMP,0,16'h0000,16'h7777,16'h8888, 16'h0000,1,0,1,1));
        apply(mk("stall_sticky", 0,1,PC_SEL_RET, 1,16'h0000,16'h7777,16'h8888, 16'h0000,1,0,1,1));
        apply(mk("rst_clear",    1,0,PC_SEL_JUMP,0,16'h0000,16'h7777,16'h8888, 16'h0000,1,0,0,0));
        apply(mk("callret_empty",0,0,PC_SEL_RET, 1,16'h9999,16'h7777,16'h8888, 16'h0001,0,0,0,1));
        apply(mk("ret_after_cre",0,0,PC_SEL_RET, 0,16'h9999,16'h7777,16'h8888, 16'h0001,1,0,0,1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
